// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP multiply-accumulate slice: OPMODE bit map,
// X/Z operand select encodings and the control words carried down the pipeline.
package dsp_pkg;

    localparam int unsigned OPMODE_W   = 8;
    localparam int unsigned OP_XSEL_LO = 0;
    localparam int unsigned OP_ZSEL_LO = 2;
    localparam int unsigned OP_PREADD  = 4;
    localparam int unsigned OP_BCIN    = 5;
    localparam int unsigned OP_PRESUB  = 6;
    localparam int unsigned OP_POSTSUB = 7;

    // X uses ZERO/M/P/C, Z uses ZERO/PCIN/P/C; M and PCIN share an encoding
    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_M    = 2'd1;
    localparam logic [1:0] SEL_PCIN = 2'd1;
    localparam logic [1:0] SEL_P    = 2'd2;
    localparam logic [1:0] SEL_C    = 2'd3;

    typedef struct packed {
        logic       valid;
        logic       cin;
        logic       sub;
        logic [1:0] zsel;
        logic [1:0] xsel;
    } post_ctl_t;

    typedef struct packed {
        logic      presub;
        logic      preadd;
        post_ctl_t post;
    } pre_ctl_t;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Generic CE-qualified pipeline register with synchronous active-low clear.
module dsp_pipe_reg #(
    parameter int unsigned N = 1
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         CE,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q
);

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            Q <= '0;
        end else if (CE) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/dsp_mac_slice.sv
// Four-stage pre-add / multiply / post-add slice with accumulate feedback,
// cascade ports and optional signed saturation of P.
module dsp_mac_slice
    import dsp_pkg::*;
#(
    parameter int unsigned AW     = 18,
    parameter int unsigned BW     = 18,
    parameter int unsigned PW     = 48,
    parameter bit          SAT_EN = 1'b0
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                CE,
    input  logic                IN_VALID,
    input  logic [AW-1:0]       A,
    input  logic [BW-1:0]       B,
    input  logic [BW-1:0]       D,
    input  logic [BW-1:0]       BCIN,
    input  logic [PW-1:0]       C,
    input  logic [PW-1:0]       PCIN,
    input  logic [OPMODE_W-1:0] OPMODE,
    input  logic                CARRYIN,
    output logic [PW-1:0]       P,
    output logic [PW-1:0]       PCOUT,
    output logic [AW+BW-1:0]    M,
    output logic [BW-1:0]       BCOUT,
    output logic                OUT_VALID,
    output logic                CARRYOUT,
    output logic                OVF
);

    localparam int unsigned MW     = AW + BW;
    localparam int unsigned CTL1_W = $bits(pre_ctl_t);
    localparam int unsigned CTL_W  = $bits(post_ctl_t);
    localparam int unsigned S1_W   = CTL1_W + AW + 2 * BW + PW;
    localparam int unsigned S2_W   = CTL_W + AW + BW + PW;
    localparam int unsigned S3_W   = CTL_W + MW + PW;
    localparam int unsigned S4_W   = PW + 3;

    pre_ctl_t        ctl1_d, ctl1_q;
    logic [AW-1:0]   a1_q;
    logic [BW-1:0]   b1_d, b1_q, d1_q;
    logic [PW-1:0]   c1_q;
    logic [S1_W-1:0] s1_q;

    post_ctl_t       ctl2_q;
    logic [AW-1:0]   a2_q;
    logic [BW-1:0]   pre2_d, pre2_q;
    logic [PW-1:0]   c2_q;
    logic [S2_W-1:0] s2_q;

    post_ctl_t       ctl3_q;
    logic [MW-1:0]   a_ext, pre_ext, m3_d, m3_q;
    logic [PW-1:0]   c3_q;
    logic [S3_W-1:0] s3_q;

    logic [PW-1:0]   x_sel, z_sel, p_d, p_q;
    logic [PW+1:0]   x_ext, z_ext, cin_ext, sum_s;
    logic            ovf_d, carry_d, valid_q, ovf_q, carry_q;
    logic [S4_W-1:0] s4_q;

    // Stage 1: operand capture and OPMODE decode
    always_comb begin
        ctl1_d           = '0;
        ctl1_d.presub    = OPMODE[OP_PRESUB];
        ctl1_d.preadd    = OPMODE[OP_PREADD];
        ctl1_d.post.sub  = OPMODE[OP_POSTSUB];
        ctl1_d.post.zsel = OPMODE[OP_ZSEL_LO +: 2];
        ctl1_d.post.xsel = OPMODE[OP_XSEL_LO +: 2];
        ctl1_d.post.cin  = CARRYIN;
        ctl1_d.post.valid = IN_VALID;
        b1_d             = OPMODE[OP_BCIN] ? BCIN : B;
    end

    dsp_pipe_reg #(.N(S1_W)) u_s1 (
        .CLK(CLK), .RSTN(RSTN), .CE(CE),
        .D({ctl1_d, A, b1_d, D, C}), .Q(s1_q)
    );
    assign {ctl1_q, a1_q, b1_q, d1_q, c1_q} = s1_q;

    // Stage 2: BW-bit pre-adder, wraps on overflow
    always_comb begin
        pre2_d = b1_q;
        if (ctl1_q.preadd) begin
            pre2_d = ctl1_q.presub ? (d1_q - b1_q) : (d1_q + b1_q);
        end
    end

    dsp_pipe_reg #(.N(S2_W)) u_s2 (
        .CLK(CLK), .RSTN(RSTN), .CE(CE),
        .D({ctl1_q.post, a1_q, pre2_d, c1_q}), .Q(s2_q)
    );
    assign {ctl2_q, a2_q, pre2_q, c2_q} = s2_q;

    // Stage 3: full-width signed multiply (low MW bits of sign-extended operands)
    assign a_ext   = {{BW{a2_q[AW-1]}}, a2_q};
    assign pre_ext = {{AW{pre2_q[BW-1]}}, pre2_q};
    assign m3_d    = a_ext * pre_ext;

    dsp_pipe_reg #(.N(S3_W)) u_s3 (
        .CLK(CLK), .RSTN(RSTN), .CE(CE),
        .D({ctl2_q, m3_d, c2_q}), .Q(s3_q)
    );
    assign {ctl3_q, m3_q, c3_q} = s3_q;

    // Stage 4: post-adder with accumulate feedback from the P register
    always_comb begin
        x_sel = '0;
        z_sel = '0;
        case (ctl3_q.xsel)
            SEL_M:   x_sel = {{(PW-MW){m3_q[MW-1]}}, m3_q};
            SEL_P:   x_sel = p_q;
            SEL_C:   x_sel = c3_q;
            default: x_sel = '0;
        endcase
        case (ctl3_q.zsel)
            SEL_PCIN: z_sel = PCIN;
            SEL_P:    z_sel = p_q;
            SEL_C:    z_sel = c3_q;
            default:  z_sel = '0;
        endcase
    end

    assign x_ext   = {{2{x_sel[PW-1]}}, x_sel};
    assign z_ext   = {{2{z_sel[PW-1]}}, z_sel};
    assign cin_ext = {{(PW+1){1'b0}}, ctl3_q.cin};
    assign sum_s   = ctl3_q.sub ? (z_ext - x_ext - cin_ext) : (z_ext + x_ext + cin_ext);

    // Unsigned bit PW differs from the signed one by the operand sign bits
    always_comb begin
        ovf_d   = (sum_s[PW+1:PW-1] != 3'b000) && (sum_s[PW+1:PW-1] != 3'b111);
        carry_d = sum_s[PW] ^ z_sel[PW-1] ^ x_sel[PW-1];
        p_d     = sum_s[PW-1:0];
        if (SAT_EN && ovf_d) begin
            p_d = sum_s[PW+1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
        end
    end

    dsp_pipe_reg #(.N(S4_W)) u_s4 (
        .CLK(CLK), .RSTN(RSTN), .CE(CE),
        .D({ctl3_q.valid, ovf_d, carry_d, p_d}), .Q(s4_q)
    );
    assign {valid_q, ovf_q, carry_q, p_q} = s4_q;

    assign P         = p_q;
    assign PCOUT     = p_q;
    assign M         = m3_q;
    assign BCOUT     = b1_q;
    assign OUT_VALID = valid_q;
    assign CARRYOUT  = carry_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Scoreboard bench for dsp_mac_slice: wrap and saturating instances side by side,
// checked against an integer-arithmetic model of each operation.
module tb_dsp_mac_slice;

    localparam int unsigned AW = 18;
    localparam int unsigned BW = 18;
    localparam int unsigned PW = 48;
    localparam int unsigned MW = AW + BW;
    localparam logic [PW-1:0] PMAX = 48'h7FFF_FFFF_FFFF;
    localparam logic [PW-1:0] PMIN = 48'h8000_0000_0000;
    localparam longint SMAX   = 64'sh0000_7FFF_FFFF_FFFF;
    localparam longint SMIN   = -64'sh0000_8000_0000_0000;
    localparam longint MASK48 = 64'sh0000_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [BW-1:0] d;
        logic [BW-1:0] bcin;
        logic [PW-1:0] c;
        logic [7:0]    opm;
        logic          cin;
        logic          v;
    } op_t;

    typedef struct packed {
        logic          v;
        logic [PW-1:0] p0;
        logic          c0;
        logic          o0;
        logic [PW-1:0] p1;
        logic          c1;
        logic          o1;
    } exp_t;

    logic clk, rstn, ce, in_valid, carryin;
    logic [AW-1:0] a;
    logic [BW-1:0] b, d, bcin;
    logic [PW-1:0] c, pcin;
    logic [7:0]    opmode;

    logic [PW-1:0] p0, pcout0, p1, pcout1;
    logic [MW-1:0] m0, m1;
    logic [BW-1:0] bcout0, bcout1;
    logic          ov0, co0, of0, ov1, co1, of1;

    exp_t          exp_q[$];
    logic [MW-1:0] m_q[$];
    logic [BW-1:0] b_q[$];
    logic [PW-1:0] pcin_tab [0:8191];
    int unsigned   e;
    logic [PW-1:0] pm0, pm1;
    exp_t          last_exp;
    logic [MW-1:0] last_m;
    int            vectors;
    int            miscompares;

    dsp_mac_slice #(.AW(AW), .BW(BW), .PW(PW), .SAT_EN(1'b0)) u_wrap (
        .CLK(clk), .RSTN(rstn), .CE(ce), .IN_VALID(in_valid),
        .A(a), .B(b), .D(d), .BCIN(bcin), .C(c), .PCIN(pcin),
        .OPMODE(opmode), .CARRYIN(carryin),
        .P(p0), .PCOUT(pcout0), .M(m0), .BCOUT(bcout0),
        .OUT_VALID(ov0), .CARRYOUT(co0), .OVF(of0)
    );

    dsp_mac_slice #(.AW(AW), .BW(BW), .PW(PW), .SAT_EN(1'b1)) u_sat (
        .CLK(clk), .RSTN(rstn), .CE(ce), .IN_VALID(in_valid),
        .A(a), .B(b), .D(d), .BCIN(bcin), .C(c), .PCIN(pcin),
        .OPMODE(opmode), .CARRYIN(carryin),
        .P(p1), .PCOUT(pcout1), .M(m1), .BCOUT(bcout1),
        .OUT_VALID(ov1), .CARRYOUT(co1), .OVF(of1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sx18(input logic [17:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sx48(input logic [47:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [PW-1:0] rand48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    function automatic op_t mk_op(input logic [AW-1:0] av, input logic [BW-1:0] bv,
                                  input logic [BW-1:0] dv, input logic [PW-1:0] cv,
                                  input logic [7:0] opm, input logic cin, input logic v);
        op_t o;
        o.a = av; o.b = bv; o.d = dv; o.bcin = BW'($urandom); o.c = cv;
        o.opm = opm; o.cin = cin; o.v = v;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a = AW'($urandom); o.b = BW'($urandom); o.d = BW'($urandom);
        o.bcin = BW'($urandom);
        case ($urandom_range(0, 3))
            0:       o.c = PMAX;
            1:       o.c = PMIN;
            default: o.c = rand48();
        endcase
        o.opm = 8'($urandom); o.cin = 1'($urandom); o.v = 1'($urandom);
        return o;
    endfunction

    // One operation as plain integer arithmetic on the operands and the previous P
    function automatic void calc(input op_t o, input logic [PW-1:0] pc, input logic [PW-1:0] pprev,
                                 input bit sat, output logic [PW-1:0] p, output logic carry,
                                 output logic ovf, output logic [MW-1:0] m);
        longint bsel, dd, pre, mm, x, z, t, cu, cinl, zu, xu;
        logic [17:0] pre_w;
        bsel = sx18(o.opm[5] ? o.bcin : o.b);
        dd   = sx18(o.d);
        pre  = bsel;
        if (o.opm[4]) begin
            pre   = o.opm[6] ? dd - bsel : dd + bsel;
            pre_w = pre[17:0];
            pre   = sx18(pre_w);
        end
        mm = sx18(o.a) * pre;
        case (o.opm[1:0])
            2'd0: x = 0;
            2'd1: x = mm;
            2'd2: x = sx48(pprev);
            default: x = sx48(o.c);
        endcase
        case (o.opm[3:2])
            2'd0: z = 0;
            2'd1: z = sx48(pc);
            2'd2: z = sx48(pprev);
            default: z = sx48(o.c);
        endcase
        cinl  = o.cin ? 64'sd1 : 64'sd0;
        t     = o.opm[7] ? z - (x + cinl) : z + x + cinl;
        ovf   = (t > SMAX) || (t < SMIN);
        zu    = z & MASK48;
        xu    = x & MASK48;
        cu    = o.opm[7] ? zu - (xu + cinl) : zu + xu + cinl;
        carry = o.opm[7] ? (cu < 0) : cu[48];
        p     = (sat && ovf) ? ((t < 0) ? PMIN : PMAX) : t[47:0];
        m     = mm[35:0];
    endfunction

    task automatic apply_inputs(input op_t o);
        a = o.a; b = o.b; d = o.d; bcin = o.bcin; c = o.c;
        opmode = o.opm; carryin = o.cin; in_valid = o.v;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_q.delete();
        b_q.delete();
        repeat (3) exp_q.push_back('0);
        repeat (2) m_q.push_back('0);
        e = 0;
        for (int i = 0; i < 3; i++) pcin_tab[i] = rand48();
        pm0 = '0;
        pm1 = '0;
    endtask

    // Drive one cycle; on a CE cycle predict the result and queue it
    task automatic drive(input op_t o, input bit ce_v);
        exp_t          ex;
        logic [MW-1:0] mx, mx1;
        rstn = 1'b1;
        ce   = ce_v;
        apply_inputs(o);
        if (ce_v) begin
            pcin = pcin_tab[e];
            pcin_tab[e+3] = rand48();
            ex.v = o.v;
            calc(o, pcin_tab[e+3], pm0, 1'b0, ex.p0, ex.c0, ex.o0, mx);
            calc(o, pcin_tab[e+3], pm1, 1'b1, ex.p1, ex.c1, ex.o1, mx1);
            pm0 = ex.p0;
            pm1 = ex.p1;
            exp_q.push_back(ex);
            m_q.push_back(mx);
            b_q.push_back(o.opm[5] ? o.bcin : o.b);
            e++;
        end else begin
            pcin = rand48();
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        ce   = 1'($urandom);
        apply_inputs(rand_op());
        pcin = rand48();
        model_reset();
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per CE-qualified edge, checks hold otherwise
    initial begin
        logic adv, inrst;
        exp_t ex;
        logic [MW-1:0] mx;
        logic [BW-1:0] bx;
        last_exp = '0;
        last_m   = '0;
        forever begin
            @(posedge clk);
            adv   = ce && rstn;
            inrst = !rstn;
            #1;
            if (inrst) begin
                chk("rst_P0", 64'(p0), 64'd0);
                chk("rst_PCOUT0", 64'(pcout0), 64'd0);
                chk("rst_M0", 64'(m0), 64'd0);
                chk("rst_BCOUT0", 64'(bcout0), 64'd0);
                chk("rst_VALID0", 64'(ov0), 64'd0);
                chk("rst_CARRY0", 64'(co0), 64'd0);
                chk("rst_OVF0", 64'(of0), 64'd0);
                chk("rst_P1", 64'(p1), 64'd0);
                chk("rst_OVF1", 64'(of1), 64'd0);
                last_exp = '0;
                last_m   = '0;
            end else if (adv) begin
                if (exp_q.size() == 0 || m_q.size() == 0 || b_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_underflow: got empty queue, want a pending entry (t=%0t)", $time);
                end else begin
                    ex = exp_q.pop_front();
                    mx = m_q.pop_front();
                    bx = b_q.pop_front();
                    chk("VALID0", 64'(ov0), 64'(ex.v));
                    chk("P0", 64'(p0), 64'(ex.p0));
                    chk("PCOUT0", 64'(pcout0), 64'(ex.p0));
                    chk("CARRY0", 64'(co0), 64'(ex.c0));
                    chk("OVF0", 64'(of0), 64'(ex.o0));
                    chk("M0", 64'(m0), 64'(mx));
                    chk("BCOUT0", 64'(bcout0), 64'(bx));
                    chk("VALID1", 64'(ov1), 64'(ex.v));
                    chk("P1", 64'(p1), 64'(ex.p1));
                    chk("PCOUT1", 64'(pcout1), 64'(ex.p1));
                    chk("CARRY1", 64'(co1), 64'(ex.c1));
                    chk("OVF1", 64'(of1), 64'(ex.o1));
                    last_exp = ex;
                    last_m   = mx;
                end
            end else begin
                chk("hold_P0", 64'(p0), 64'(last_exp.p0));
                chk("hold_M0", 64'(m0), 64'(last_m));
                chk("hold_VALID0", 64'(ov0), 64'(last_exp.v));
                chk("hold_P1", 64'(p1), 64'(last_exp.p1));
            end
        end
    end

    initial begin
        op_t hold;
        vectors     = 0;
        miscompares = 0;
        rstn = 1'b0;
        ce   = 1'b0;
        apply_inputs('0);
        pcin = '0;
        hold = mk_op('0, '0, '0, '0, 8'h08, 1'b0, 1'b0);

        reset_dut();
        reset_dut();
        chk("reset_P", 64'(p0), 64'd0);
        chk("reset_VALID", 64'(ov0), 64'd0);

        // pre-subtract: 3 * (7 - 5)
        repeat (4) drive(mk_op(18'd3, 18'd5, 18'd7, '0, 8'h51, 1'b0, 1'b1), 1'b1);
        chk("presub_P", 64'(p0), 64'd6);
        chk("presub_M", 64'(m0), 64'd6);
        chk("presub_VALID", 64'(ov0), 64'd1);

        // negative product sign-extended into P
        repeat (4) drive(mk_op(18'h3FFFE, 18'd4, '0, '0, 8'h01, 1'b0, 1'b1), 1'b1);
        chk("neg_M", 64'(m0), 64'h0000_000F_FFFF_FFF8);
        chk("neg_P", 64'(p0), 64'h0000_FFFF_FFFF_FFF8);
        chk("neg_CARRY", 64'(co0), 64'd0);

        // back-to-back accumulation
        drive(mk_op(18'd2, 18'd3, '0, '0, 8'h01, 1'b0, 1'b1), 1'b1);
        repeat (3) drive(mk_op(18'd2, 18'd3, '0, '0, 8'h09, 1'b0, 1'b1), 1'b1);
        chk("acc_P1", 64'(p0), 64'd6);
        for (int k = 2; k <= 4; k++) begin
            drive(hold, 1'b1);
            chk("acc_Pn", 64'(p0), 64'(6 * k));
        end

        // positive overflow: wrap vs saturate
        repeat (4) drive(mk_op('0, '0, '0, PMAX, 8'h0F, 1'b0, 1'b1), 1'b1);
        chk("ovf_wrap_P", 64'(p0), 64'h0000_FFFF_FFFF_FFFE);
        chk("ovf_wrap_OVF", 64'(of0), 64'd1);
        chk("ovf_sat_P", 64'(p1), 64'(PMAX));
        chk("ovf_sat_OVF", 64'(of1), 64'd1);

        // CE stall mid-pipeline
        drive(mk_op(18'd5, 18'd7, '0, '0, 8'h01, 1'b0, 1'b1), 1'b1);
        repeat (3) drive(rand_op(), 1'b0);
        repeat (3) drive(hold, 1'b1);
        chk("stall_P", 64'(p0), 64'd35);
        chk("stall_VALID", 64'(ov0), 64'd1);

        // reset with three valid ops in flight
        repeat (3) drive(mk_op(18'd9, 18'd9, '0, '0, 8'h01, 1'b0, 1'b1), 1'b1);
        reset_dut();
        chk("flush_P", 64'(p0), 64'd0);
        chk("flush_M", 64'(m0), 64'd0);
        for (int k = 0; k < 4; k++) begin
            drive(mk_op('0, '0, '0, '0, 8'h00, 1'b0, 1'b0), 1'b1);
            chk("flush_VALID", 64'(ov0), 64'd0);
        end

        // randomized traffic with CE gaps and occasional resets
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) reset_dut();
            else drive(rand_op(), r >= 15);
        end

        repeat (4) drive(hold, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dsp_mac_slice.md
DSP_MAC_SLICE -- requirements
Module: dsp_mac_slice

Interface
REQ-001 Parameter AW, default 18: A operand width, two's complement.
REQ-002 Parameter BW, default 18: B/D/BCIN operand width, two's complement.
REQ-003 Parameter PW, default 48: C/PCIN/P width; SHALL satisfy PW >= AW+BW+1.
REQ-004 Parameter SAT_EN, default 0: 1 enables signed saturation of P.
REQ-005 CLK  input  1  single clock, all state updates on rising edge.
REQ-006 RSTN  input  1  synchronous, active-low reset for all registers.
REQ-007 CE  input  1  pipeline advance enable; 0 holds every register.
REQ-008 IN_VALID  input  1  marks the sampled operand set as a real operation.
REQ-009 A  input  AW;  B, D, BCIN  input  BW;  C, PCIN  input  PW  data operands.
REQ-010 OPMODE  input  8  per-operation control, sampled with operands.
REQ-011 CARRYIN  input  1  post-adder carry/borrow input.
REQ-012 P, PCOUT  output  PW  result and cascade copy (PCOUT == P at all times).
REQ-013 M  output  AW+BW  registered multiplier product.
REQ-014 BCOUT  output  BW  registered stage-1 B path (cascade).
REQ-015 OUT_VALID  output  1  P holds the result of a valid operation.
REQ-016 CARRYOUT  output  1  post-adder carry out; OVF  output  1  signed overflow flag.

Function
REQ-017 Stage 1 (CE=1): register A, D, C, CARRYIN, OPMODE, IN_VALID; B path registers OPMODE[5] ? BCIN : B; BCOUT = stage-1 B register.
REQ-018 Stage 2: pre-adder result = OPMODE[4] ? (OPMODE[6] ? D1-B1 : D1+B1) : B1, truncated to BW bits (wrap); A passes unchanged.
REQ-019 Stage 3: M = signed(A2) * signed(preadd2), full AW+BW bits, no truncation.
REQ-020 Stage 4: X = OPMODE[1:0] {0: zero, 1: M sign-extended to PW, 2: current P, 3: C}; Z = OPMODE[3:2] {0: zero, 1: PCIN, 2: current P, 3: C}.
REQ-021 Stage 4: P_next = OPMODE[7] ? Z-(X+CIN) : Z+X+CIN, computed PW+1 bits; CARRYOUT = bit PW.
REQ-022 OPMODE, CARRYIN, C, PCIN selection SHALL use the copies travelling with the operation in the pipeline, never the live inputs (except PCIN, sampled at stage 4).
REQ-023 Latency: operands sampled on CE edge k appear on P/OUT_VALID after CE edge k+3 (4 CE-qualified edges total); CE=0 cycles add no latency and change nothing.
REQ-024 OVF = 1 when signed result of REQ-021 exceeds PW-bit range; registered with P.
REQ-025 SAT_EN=1 and overflow: P = max positive (0x7FF..F) or min negative (0x800..0) by sign of true result; SAT_EN=0: P wraps.
REQ-026 Accumulate (X or Z = P) uses P as held in stage 4 at that edge, so back-to-back accumulations chain with no bubble.
REQ-027 OUT_VALID = stage-3 valid at each CE edge; invalid operations still update P (data path is not gated by valid).
REQ-028 Simultaneous RSTN=0 and CE=1: reset wins.

Reset
REQ-029 RSTN=0 at a rising edge clears every pipeline register, P, PCOUT, M, BCOUT, CARRYOUT, OVF, OUT_VALID to 0, regardless of CE.
REQ-030 Reset mid-operation discards all in-flight operations; first valid output after release appears 4 CE edges after first valid sample.

Structure
REQ-031 Package dsp_pkg SHALL hold OPMODE bit-index constants and X/Z select encodings (SEL_ZERO, SEL_M, SEL_P, SEL_C, SEL_PCIN).
REQ-032 One sub-module dsp_pipe_reg (parameter N; CLK, RSTN, CE, D, Q) SHALL implement every pipeline register.

Verification
REQ-033 A=3, B=5, D=7, OPMODE=0x51 (pre-sub, X=M, Z=0), IN_VALID=1, CE=1 -> after 4 edges P=6, M=6, OUT_VALID=1.
REQ-034 A=-2, B=4, OPMODE=0x01 -> M=-8, P=0xFFFF_FFFF_FFF8 (PW=48), CARRYOUT=0.
REQ-035 Accumulate: first op OPMODE=0x01 then 3 ops OPMODE=0x09 (Z=P), A=2, B=3 each -> P sequence 6, 12, 18, 24 on consecutive edges.
REQ-036 SAT_EN=1, C=0x7FFF_FFFF_FFFF, OPMODE=0x0F (X=C, Z=C) -> P=0x7FFF_FFFF_FFFF, OVF=1; SAT_EN=0 same stimulus -> P=0xFFFF_FFFF_FFFE, OVF=1.
REQ-037 Hold CE=0 for 3 cycles mid-pipeline -> P, M, OUT_VALID frozen; result appears 4 CE edges after sampling.
REQ-038 RSTN=0 for one edge with 3 ops in flight -> all outputs 0 next cycle; no stale OUT_VALID afterwards.
